// File: rtl/ps2_kbd_rx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - receive FSM state encoding
//   - scan-code prefix bytes (extended / break)
//   - key-word field positions and a helper that packs a key word
// ---------------------------------------------------------------------------
package ps2_kbd_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int KEY_W    = 10;
  localparam int EXT_BIT  = 9;
  localparam int BRK_BIT  = 8;
  localparam int CODE_MSB = 7;
  localparam int CODE_LSB = 0;

  // Key word layout: {ext, brk, code[7:0]}
  function automatic logic [KEY_W-1:0] make_key(input logic ext, input logic brk,
                                                input logic [7:0] code);
    logic [KEY_W-1:0] key;
    key                    = '0;
    key[EXT_BIT]           = ext;
    key[BRK_BIT]           = brk;
    key[CODE_MSB:CODE_LSB] = code;
    return key;
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx_fifo
// Small synchronous FIFO for key words. The head is held in a register
// (dout) that is recomputed every cycle, so after a pop the next entry is
// visible on the following cycle with no extra read latency. dout is zero
// while the FIFO is empty.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   push/din  write strobe and data (accepted when not full, or when full
//             together with a pop)
//   pop       read strobe (ignored while empty)
//   dout      registered head of the FIFO
//   empty     no entries
//   full      DEPTH entries
// ---------------------------------------------------------------------------
module ps2_kbd_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next, wr_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop && (count_reg != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && ((count_reg != DEPTH_C) || pop_ok);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    dout_next   = '0;
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
    if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    // The new head is the word being written this cycle only when the
    // FIFO would otherwise have been empty; else it is already in memory.
    if (count_next == '0)
      dout_next = '0;
    else if (push_ok && (rd_ptr_next == wr_ptr_reg))
      dout_next = din;
    else
      dout_next = mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      dout_reg   <= dout_next;
    end
  end

  assign dout  = dout_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_C);

endmodule

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// PS/2 keyboard receiver. Synchronises and filters the PS/2 pins, receives
// 11-bit device-to-host frames on falling edges of the filtered clock,
// folds E0 / F0 prefixes into a 10-bit key word {ext,brk,code} and queues
// the words in a FIFO whose head is presented to the CPU.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   ps2_clk      raw PS/2 clock pin
//   ps2_data     raw PS/2 data pin
//   rd_ack       one-cycle pop strobe for the FIFO head
//   ps2kb_key    FIFO head {ext,brk,code}, zero when empty
//   key_valid    FIFO not empty
//   overflow     sticky flag: a key word was dropped on a full FIFO
//   parity_err   one-cycle pulse on a rejected frame (parity or stop error)
// ---------------------------------------------------------------------------
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             rd_ack,
  output logic [KEY_W-1:0] ps2kb_key,
  output logic             key_valid,
  output logic             overflow,
  output logic             parity_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  // ---------------- synchroniser (idle level of both pins is 1) -----------
  logic clk_meta_reg, clk_sync_reg, data_meta_reg, data_sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_reg  <= 1'b1;
      clk_sync_reg  <= 1'b1;
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      clk_meta_reg  <= ps2_clk;
      clk_sync_reg  <= clk_meta_reg;
      data_meta_reg <= ps2_data;
      data_sync_reg <= data_meta_reg;
    end
  end

  // ---------------- clock glitch filter + fall detector -------------------
  // The filtered clock follows the synchronised pin only after FILTER_LEN
  // consecutive samples disagree with it; any agreeing sample restarts the run.
  logic [FW-1:0] filt_cnt_reg;
  logic          filt_clk_reg, filt_prev_reg;
  logic          fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt_reg  <= '0;
      filt_clk_reg  <= 1'b1;
      filt_prev_reg <= 1'b1;
    end else begin
      filt_prev_reg <= filt_clk_reg;
      if (clk_sync_reg == filt_clk_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_LAST) begin
        filt_clk_reg <= clk_sync_reg;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  assign fall = filt_prev_reg && !filt_clk_reg;

  // ---------------- receive FSM ------------------------------------------
  ps2_state_t    state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic [TW-1:0] to_cnt_reg;
  logic          timeout_hit, accept, reject;

  assign timeout_hit = (state_reg != ST_IDLE) && !fall && (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      to_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      // Counts idle cycles since the last fall while a frame is open.
      if ((state_reg == ST_IDLE) || fall)
        to_cnt_reg <= '0;
      else
        to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    accept       = 1'b0;
    reject       = 1'b0;
    if (timeout_hit) begin
      state_next = ST_IDLE;
    end else if (fall) begin
      case (state_reg)
        ST_IDLE: begin
          if (!data_sync_reg) begin
            state_next   = ST_DATA;
            bit_cnt_next = '0;
          end
        end
        ST_DATA: begin
          // LSB arrives first, so shift in from the top.
          shift_next   = {data_sync_reg, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) state_next = ST_PARITY;
        end
        ST_PARITY: begin
          parity_next = data_sync_reg;
          state_next  = ST_STOP;
        end
        ST_STOP: begin
          if (data_sync_reg && (^{shift_reg, parity_reg}))
            accept = 1'b1;
          else
            reject = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------- prefix decoder ----------------------------------------
  logic             ext_reg, brk_reg, push_reg, perr_reg, overflow_reg;
  logic [KEY_W-1:0] word_reg;
  logic             fifo_full, fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_reg  <= 1'b0;
      brk_reg  <= 1'b0;
      push_reg <= 1'b0;
      perr_reg <= 1'b0;
      word_reg <= '0;
    end else begin
      push_reg <= 1'b0;
      perr_reg <= reject;
      if (reject) begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end else if (accept) begin
        if (shift_reg == PS2_EXT) begin
          ext_reg <= 1'b1;
        end else if (shift_reg == PS2_BRK) begin
          brk_reg <= 1'b1;
        end else begin
          push_reg <= 1'b1;
          word_reg <= make_key(ext_reg, brk_reg, shift_reg);
          ext_reg  <= 1'b0;
          brk_reg  <= 1'b0;
        end
      end
    end
  end

  // A push into a full FIFO only loses data when no pop frees a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow_reg <= 1'b0;
    else if (push_reg && fifo_full && !rd_ack)
      overflow_reg <= 1'b1;
  end

  ps2_kbd_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_reg),
    .din   (word_reg),
    .pop   (rd_ack),
    .dout  (ps2kb_key),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign key_valid  = !fifo_empty;
  assign overflow   = overflow_reg;
  assign parity_err = perr_reg;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;

  localparam int FL    = 8;
  localparam int TO    = 2000;
  localparam int DEPTH = 8;
  localparam int HALF  = 30;   // PS/2 half bit period in clk cycles

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rd_ack;
  logic [9:0] ps2kb_key;
  logic       key_valid, overflow, parity_err;

  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_ack     (rd_ack),
    .ps2kb_key  (ps2kb_key),
    .key_valid  (key_valid),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // parity_err pulse monitor
  int   pe_pulses = 0;
  int   pe_cycles = 0;
  logic pe_prev   = 1'b0;
  always @(negedge clk) begin
    if (parity_err === 1'b1) begin
      pe_cycles++;
      if (!pe_prev) pe_pulses++;
    end
    pe_prev = (parity_err === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [9:0] mq[$];
  bit m_ext, m_brk, m_ovf;

  function automatic void model_reset();
    mq.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0;
  endfunction

  // err: 0 good frame, 1 bad parity, 2 bad stop. Returns expected parity_err pulses.
  function automatic int model_frame(input logic [7:0] code, input int err);
    if (err != 0) begin
      m_ext = 0; m_brk = 0;
      return 1;
    end
    if (code == 8'hE0) m_ext = 1;
    else if (code == 8'hF0) m_brk = 1;
    else begin
      if (mq.size() >= DEPTH) m_ovf = 1;
      else mq.push_back({m_ext, m_brk, code});
      m_ext = 0; m_brk = 0;
    end
    return 0;
  endfunction

  function automatic void model_pop();
    if (mq.size() > 0) void'(mq.pop_front());
  endfunction

  task automatic check_model(input string tag);
    logic [9:0] head;
    head = (mq.size() > 0) ? mq[0] : 10'h000;
    check({tag, " key"},      ps2kb_key, head);
    check({tag, " valid"},    key_valid, (mq.size() > 0));
    check({tag, " overflow"}, overflow,  m_ovf);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int valid_edge;
  int lat = FL + 4;

  // Drives nbits of a frame. pop_sync pulses rd_ack in the cycle the stop
  // bit's word is pushed. glitch_bit>=0 adds a short low pulse on ps2_clk
  // after that bit.
  task automatic send_frame(input logic [7:0] code, input int err, input int nbits,
                            input bit pop_sync, input int glitch_bit);
    logic [10:0] bits;
    bits = {(err == 2) ? 1'b0 : 1'b1, (~^code) ^ (err == 1), code, 1'b0};
    valid_edge = 0;
    for (int b = 0; b < nbits; b++) begin
      ps2_data = bits[b];
      step(HALF);
      ps2_clk = 1'b0;
      for (int i = 1; i <= HALF; i++) begin
        @(posedge clk); #1;
        rd_ack = pop_sync && (b == 10) && (i == lat - 1);
        if (b == 10 && valid_edge == 0 && key_valid === 1'b1) valid_edge = i;
      end
      rd_ack  = 1'b0;
      ps2_clk = 1'b1;
      if (b == glitch_bit) begin
        step(8);
        ps2_clk = 1'b0;
        step(FL / 2);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
    step(HALF);
  endtask

  task automatic pop();
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    step(1);
  endtask

  typedef struct {
    logic [7:0] code;
    int         err;
    logic [9:0] exp_key;
    logic       exp_valid;
    int         exp_perr;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int p0, c0, ep;
    logic [7:0] code;
    int err;

    tbl[0]  = '{8'hF0, 0, 10'h000, 1'b0, 0};
    tbl[1]  = '{8'h1C, 0, 10'h11C, 1'b1, 0};
    tbl[2]  = '{8'hE0, 0, 10'h000, 1'b0, 0};
    tbl[3]  = '{8'hF0, 0, 10'h000, 1'b0, 0};
    tbl[4]  = '{8'h75, 0, 10'h375, 1'b1, 0};
    tbl[5]  = '{8'h1C, 0, 10'h01C, 1'b1, 0};
    tbl[6]  = '{8'h1C, 1, 10'h000, 1'b0, 1};
    tbl[7]  = '{8'hE0, 0, 10'h000, 1'b0, 0};
    tbl[8]  = '{8'h33, 1, 10'h000, 1'b0, 1};
    tbl[9]  = '{8'h75, 0, 10'h075, 1'b1, 0};
    tbl[10] = '{8'h6B, 2, 10'h000, 1'b0, 1};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_ack = 1'b0;
    model_reset();
    step(3);
    check("reset key", ps2kb_key, 10'h000);
    check("reset valid", key_valid, 1'b0);
    check("reset overflow", overflow, 1'b0);
    check("reset parity_err", parity_err, 1'b0);
    rst = 1'b0;
    step(5);

    // Single frame, latency window and pop
    send_frame(8'h1C, 0, 11, 0, -1);
    check("t1 latency in window", (valid_edge >= FL + 3 && valid_edge <= FL + 6), 1'b1);
    if (valid_edge != 0) lat = valid_edge;
    check("t1 key", ps2kb_key, 10'h01C);
    check("t1 valid", key_valid, 1'b1);
    pop();
    check("t1 key after pop", ps2kb_key, 10'h000);
    check("t1 valid after pop", key_valid, 1'b0);

    // Prefix folding and rejected frames
    for (int v = 0; v < 11; v++) begin
      p0 = pe_pulses; c0 = pe_cycles;
      send_frame(tbl[v].code, tbl[v].err, 11, 0, -1);
      step(2);
      $display("[TB] vec %0d code=%0h err=%0d key=%0h valid=%0b", v, tbl[v].code, tbl[v].err,
               ps2kb_key, key_valid);
      check($sformatf("vec%0d key", v), ps2kb_key, tbl[v].exp_key);
      check($sformatf("vec%0d valid", v), key_valid, tbl[v].exp_valid);
      check($sformatf("vec%0d perr pulses", v), pe_pulses - p0, tbl[v].exp_perr);
      check($sformatf("vec%0d perr cycles", v), pe_cycles - c0, tbl[v].exp_perr);
      if (tbl[v].exp_valid) begin
        pop();
        check($sformatf("vec%0d empty after pop", v), key_valid, 1'b0);
      end
    end
    check("table overflow", overflow, 1'b0);

    // Fill, push+pop while full, overflow, drain
    for (int i = 0; i < DEPTH; i++) begin
      code = 8'h10 + 8'(i);
      void'(model_frame(code, 0));
      send_frame(code, 0, 11, 0, -1);
    end
    check_model("t4 full");
    model_pop();
    void'(model_frame(8'h50, 0));
    send_frame(8'h50, 0, 11, 1, -1);
    check_model("t4 push+pop full");
    void'(model_frame(8'h60, 0));
    send_frame(8'h60, 0, 11, 0, -1);
    check_model("t4 dropped");
    for (int i = 0; i < DEPTH; i++) begin
      check_model($sformatf("t4 drain%0d", i));
      model_pop();
      pop();
    end
    check_model("t4 drained");

    // Timeout on a partial frame
    p0 = pe_pulses;
    send_frame(8'h5A, 0, 5, 0, -1);
    step(TO + 600);
    check("t5 no perr on timeout", pe_pulses - p0, 0);
    void'(model_frame(8'h29, 0));
    send_frame(8'h29, 0, 11, 0, -1);
    check_model("t5 after timeout");
    model_pop();
    pop();

    // Glitch during a frame, then reset mid-frame during a glitch
    void'(model_frame(8'h34, 0));
    send_frame(8'h34, 0, 11, 0, 3);
    check_model("t6 glitch frame");
    send_frame(8'h77, 0, 4, 0, -1);
    ps2_clk = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    model_reset();
    check_model("t6 in reset");
    check("t6 perr in reset", parity_err, 1'b0);
    step(2);
    ps2_clk = 1'b1;
    step(1);
    rst = 1'b0;
    step(FL + 4);
    check_model("t6 after reset");
    void'(model_frame(8'h1C, 0));
    send_frame(8'h1C, 0, 11, 0, -1);
    check_model("t6 frame after reset");
    model_pop();
    pop();

    // Randomised frames against the reference model
    for (int n = 0; n < 24; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) code = 8'hE0;
      else if (r == 1) code = 8'hF0;
      else begin
        code = 8'($urandom_range(0, 255));
        if (code == 8'hE0 || code == 8'hF0) code = 8'h1C;
      end
      err = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      p0 = pe_pulses;
      ep = model_frame(code, err);
      send_frame(code, err, 11, 0, -1);
      step(2);
      $display("[TB] rnd %0d code=%0h err=%0d key=%0h valid=%0b ovf=%0b", n, code, err,
               ps2kb_key, key_valid, overflow);
      check_model($sformatf("rnd%0d", n));
      check($sformatf("rnd%0d perr", n), pe_pulses - p0, ep);
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) begin
        model_pop();
        pop();
        check_model($sformatf("rnd%0d pop%0d", n, k));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
